// File: rtl/ascon_arbiter_if.sv
// ascon_arbiter_if: requester-side channel bundle shared by all NREQ channels.
// master = requesters (drive req_*, key/bdi streams, bdo ready/eoo),
// slave = arbiter (drives grant/done/auth, per-channel readies, broadcast bdo).
interface ascon_arbiter_if #(
  parameter int NREQ = 2,
  parameter int CCW = 32
);
  localparam int CCWD8 = CCW / 8;
  logic [NREQ-1:0] req_valid;
  logic [4*NREQ-1:0] req_mode;
  logic [NREQ-1:0] req_grant;
  logic [NREQ-1:0] req_done;
  logic [NREQ-1:0] req_auth;
  logic [NREQ-1:0] req_auth_valid;
  logic busy;
  logic [2:0] grant_id;
  logic [CCW*NREQ-1:0] ch_key;
  logic [NREQ-1:0] ch_key_valid;
  logic [NREQ-1:0] ch_key_ready;
  logic [CCW*NREQ-1:0] ch_bdi;
  logic [CCWD8*NREQ-1:0] ch_bdi_valid;
  logic [4*NREQ-1:0] ch_bdi_type;
  logic [NREQ-1:0] ch_bdi_eot;
  logic [NREQ-1:0] ch_bdi_eoi;
  logic [NREQ-1:0] ch_bdi_ready;
  logic [CCW-1:0] ch_bdo;
  logic [3:0] ch_bdo_type;
  logic ch_bdo_eot;
  logic [NREQ-1:0] ch_bdo_valid;
  logic [NREQ-1:0] ch_bdo_ready;
  logic [NREQ-1:0] ch_bdo_eoo;
  modport master (
    output req_valid, req_mode, ch_key, ch_key_valid, ch_bdi, ch_bdi_valid, ch_bdi_type,
           ch_bdi_eot, ch_bdi_eoi, ch_bdo_ready, ch_bdo_eoo,
    input  req_grant, req_done, req_auth, req_auth_valid, busy, grant_id, ch_key_ready,
           ch_bdi_ready, ch_bdo, ch_bdo_type, ch_bdo_eot, ch_bdo_valid
  );
  modport slave (
    input  req_valid, req_mode, ch_key, ch_key_valid, ch_bdi, ch_bdi_valid, ch_bdi_type,
           ch_bdi_eot, ch_bdi_eoi, ch_bdo_ready, ch_bdo_eoo,
    output req_grant, req_done, req_auth, req_auth_valid, busy, grant_id, ch_key_ready,
           ch_bdi_ready, ch_bdo, ch_bdo_type, ch_bdo_eot, ch_bdo_valid
  );
endinterface

// File: rtl/ascon_arbiter.sv
// ascon_arbiter: round-robin owner of one ascon_core among NREQ requester channels.
// Ports: clk, rst (sync, active-high); ch = requester bundle (slave modport);
// core_* = mirrored ascon_core ports (key/bdi/mode/bdo_ready/bdo_eoo out, rest in).
module ascon_arbiter #(
  parameter int NREQ = 2,
  parameter int CCW = 32,
  parameter int CCWD8 = CCW / 8
) (
  input  logic             clk,
  input  logic             rst,
  ascon_arbiter_if.slave   ch,
  output logic [CCW-1:0]   core_key,
  output logic             core_key_valid,
  input  logic             core_key_ready,
  output logic [CCW-1:0]   core_bdi,
  output logic [CCWD8-1:0] core_bdi_valid,
  input  logic             core_bdi_ready,
  output logic [3:0]       core_bdi_type,
  output logic             core_bdi_eot,
  output logic             core_bdi_eoi,
  output logic [3:0]       core_mode,
  input  logic [CCW-1:0]   core_bdo,
  input  logic             core_bdo_valid,
  output logic             core_bdo_ready,
  input  logic [3:0]       core_bdo_type,
  input  logic             core_bdo_eot,
  output logic             core_bdo_eoo,
  input  logic             core_auth,
  input  logic             core_auth_valid,
  input  logic             core_done
);
  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;
  state_t state;
  logic [NREQ-1:0] active;
  logic [2:0] rr, pick, pick_hi, pick_lo;
  logic found, found_hi;
  for (genvar i = 0; i < NREQ; i++) begin : g_act
    assign active[i] = ch.req_valid[i] && ch.req_mode[4*i +: 4] != 4'd0;
  end
  // Lowest active index at or above rr wins; otherwise wrap to the lowest active index.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    found_hi = 1'b0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        pick_lo = 3'(i);
        found = 1'b1;
        if (3'(i) >= rr) begin
          pick_hi = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end
  // busy marks START/BUSY/RELEASE and req_grant is one-hot then, zero in IDLE,
  // so both double as the routing enable and the channel select mask.
  assign core_key       = ch.busy ? CCW'(ch.ch_key >> (CCW * ch.grant_id)) : '0;
  assign core_key_valid = |(ch.ch_key_valid & ch.req_grant);
  assign core_bdi       = ch.busy ? CCW'(ch.ch_bdi >> (CCW * ch.grant_id)) : '0;
  assign core_bdi_valid = ch.busy ? CCWD8'(ch.ch_bdi_valid >> (CCWD8 * ch.grant_id)) : '0;
  assign core_bdi_type  = ch.busy ? 4'(ch.ch_bdi_type >> (4 * ch.grant_id)) : '0;
  assign core_bdi_eot   = |(ch.ch_bdi_eot & ch.req_grant);
  assign core_bdi_eoi   = |(ch.ch_bdi_eoi & ch.req_grant);
  assign core_bdo_ready = |(ch.ch_bdo_ready & ch.req_grant);
  assign core_bdo_eoo   = |(ch.ch_bdo_eoo & ch.req_grant);
  assign ch.ch_key_ready = ch.req_grant & {NREQ{core_key_ready}};
  assign ch.ch_bdi_ready = ch.req_grant & {NREQ{core_bdi_ready}};
  assign ch.ch_bdo_valid = ch.req_grant & {NREQ{core_bdo_valid}};
  assign ch.ch_bdo       = core_bdo;
  assign ch.ch_bdo_type  = core_bdo_type;
  assign ch.ch_bdo_eot   = core_bdo_eot;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      ch.req_grant <= '0;
      ch.req_done <= '0;
      ch.req_auth <= '0;
      ch.req_auth_valid <= '0;
      ch.busy <= 1'b0;
      ch.grant_id <= '0;
      core_mode <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state <= START;
          ch.req_grant <= NREQ'(1) << pick;
          ch.busy <= 1'b1;
          ch.grant_id <= pick;
          core_mode <= 4'(ch.req_mode >> (4 * pick));
        end
        START: begin
          state <= BUSY;
          core_mode <= '0;
        end
        BUSY: if (core_done) begin
          state <= RELEASE;
          ch.req_done <= ch.req_grant;
          ch.req_auth <= ch.req_grant & {NREQ{core_auth}};
          ch.req_auth_valid <= ch.req_grant & {NREQ{core_auth_valid}};
        end
        RELEASE: begin
          state <= IDLE;
          rr <= (ch.grant_id == 3'(NREQ - 1)) ? 3'd0 : ch.grant_id + 3'd1;
          ch.req_grant <= '0;
          ch.req_done <= '0;
          ch.req_auth <= '0;
          ch.req_auth_valid <= '0;
          ch.busy <= 1'b0;
          ch.grant_id <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_arbiter.sv
// tb_ascon_arbiter: scoreboard bench for ascon_arbiter with a behavioural stand-in core.
module tb_ascon_arbiter;
  localparam int NREQ = 2;
  localparam int CCW = 32;
  localparam int TMO = 500;
  localparam logic [3:0] M_ENC = 4'd1, M_DEC = 4'd2, M_HASH = 4'd3, M_XOF = 4'd4, M_CXOF = 4'd5;

  typedef struct {int ch; logic [3:0] mode;} gnt_t;
  typedef struct {int ch; logic [31:0] data; logic eot; logic [3:0] typ;} bdo_t;
  typedef struct {int ch; logic av; logic auth;} done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] core_key, core_bdi, core_bdo;
  logic core_key_valid, core_key_ready, core_bdi_ready, core_bdi_eot, core_bdi_eoi;
  logic [3:0] core_bdi_valid, core_bdi_type, core_mode, core_bdo_type;
  logic core_bdo_valid, core_bdo_ready, core_bdo_eot, core_bdo_eoo;
  logic core_auth, core_auth_valid, core_done;

  ascon_arbiter_if #(.NREQ(NREQ), .CCW(CCW)) ifc ();

  ascon_arbiter #(.NREQ(NREQ), .CCW(CCW)) dut (
    .clk(clk), .rst(rst), .ch(ifc.slave),
    .core_key(core_key), .core_key_valid(core_key_valid), .core_key_ready(core_key_ready),
    .core_bdi(core_bdi), .core_bdi_valid(core_bdi_valid), .core_bdi_ready(core_bdi_ready),
    .core_bdi_type(core_bdi_type), .core_bdi_eot(core_bdi_eot), .core_bdi_eoi(core_bdi_eoi),
    .core_mode(core_mode), .core_bdo(core_bdo), .core_bdo_valid(core_bdo_valid),
    .core_bdo_ready(core_bdo_ready), .core_bdo_type(core_bdo_type), .core_bdo_eot(core_bdo_eot),
    .core_bdo_eoo(core_bdo_eoo), .core_auth(core_auth), .core_auth_valid(core_auth_valid),
    .core_done(core_done)
  );

  int checks = 0, errs = 0, cyc = 0, last_done = -100, done_cnt = 0;
  bit prev_nz = 1'b0;
  gnt_t exp_gnt[$];
  bdo_t exp_bdo[$];
  done_t exp_done[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int onum(input logic [3:0] m);
    return m == M_ENC ? 4 : m == M_HASH ? 8 : (m == M_XOF || m == M_CXOF) ? 4 : 0;
  endfunction

  // Stand-in core: XOR-accumulates absorbed words, squeezes acc+i, auth = (acc == 0) for DEC.
  logic [1:0] cst;
  logic [3:0] cmode;
  logic [31:0] acc, acc_nx;
  int ocnt;
  always_comb begin
    core_key_ready = cst == 2'd1 && (cmode == M_ENC || cmode == M_DEC);
    core_bdi_ready = cst == 2'd1;
    core_bdo_valid = cst == 2'd2 && ocnt < onum(cmode);
    core_bdo = acc + 32'(ocnt);
    core_bdo_type = cmode;
    core_bdo_eot = ocnt == onum(cmode) - 1;
    acc_nx = acc ^ ((core_key_valid && core_key_ready) ? core_key : 32'd0)
                 ^ ((core_bdi_valid != 4'd0 && core_bdi_ready)
                    ? (core_bdi ^ {23'd0, core_bdi_eot, core_bdi_type, core_bdi_valid}) : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cst <= 2'd0; cmode <= '0; acc <= '0; ocnt <= 0;
      core_done <= 1'b0; core_auth <= 1'b0; core_auth_valid <= 1'b0;
    end else if (core_mode != 4'd0) begin
      cst <= 2'd1; cmode <= core_mode; acc <= '0; ocnt <= 0;
      core_done <= 1'b0; core_auth <= 1'b0; core_auth_valid <= 1'b0;
    end else if (cst == 2'd1) begin
      acc <= acc_nx;
      if (core_bdi_valid != 4'd0 && core_bdi_ready && core_bdi_eoi) cst <= 2'd2;
    end else if (cst == 2'd2 && ocnt == onum(cmode)) begin
      cst <= 2'd0;
      core_done <= 1'b1;
      core_auth_valid <= cmode == M_DEC;
      core_auth <= cmode == M_DEC && acc == 32'd0;
    end else if (core_bdo_valid && core_bdo_ready) begin
      ocnt <= ocnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      chk("route_gate", 64'((ifc.ch_key_ready | ifc.ch_bdi_ready | ifc.ch_bdo_valid) & ~ifc.req_grant), 0);
      chk("busy_grant", 64'(ifc.busy), 64'(ifc.req_grant != '0));
      if (core_mode != 4'd0) begin
        chk("mode_pulse", 64'(prev_nz), 0);
        chk("start_gap", 64'(cyc - last_done >= 2), 1);
        if (exp_gnt.size() == 0) chk("start_unexp", 1, 0);
        else begin
          gnt_t g;
          g = exp_gnt.pop_front();
          chk("start_ch", 64'(ifc.grant_id), 64'(g.ch));
          chk("start_mode", 64'(core_mode), 64'(g.mode));
          chk("start_grant", 64'(ifc.req_grant), 64'(1) << g.ch);
        end
      end
      prev_nz = core_mode != 4'd0;
      if ((ifc.ch_bdo_valid & ifc.ch_bdo_ready) != '0) begin
        if (exp_bdo.size() == 0) chk("bdo_unexp", 1, 0);
        else begin
          bdo_t b;
          b = exp_bdo.pop_front();
          chk("bdo_ch", 64'(ifc.ch_bdo_valid), 64'(1) << b.ch);
          chk("bdo_data", 64'(ifc.ch_bdo), 64'(b.data));
          chk("bdo_eot", 64'(ifc.ch_bdo_eot), 64'(b.eot));
          chk("bdo_type", 64'(ifc.ch_bdo_type), 64'(b.typ));
        end
      end
      if (ifc.req_done != '0) begin
        last_done = cyc;
        done_cnt++;
        if (exp_done.size() == 0) chk("done_unexp", 1, 0);
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_ch", 64'(ifc.req_done), 64'(1) << d.ch);
          chk("auth_valid", 64'(ifc.req_auth_valid), 64'(d.av) << d.ch);
          chk("auth", 64'(ifc.req_auth), 64'(d.auth) << d.ch);
        end
      end
    end
  end

  task automatic wait_rdy(input int c, input bit key);
    int n = 0;
    while (!(key ? ifc.ch_key_ready[c] : ifc.ch_bdi_ready[c]) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk(key ? "key_tmo" : "bdi_tmo", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_op(input int c, input logic [3:0] mode, input int nkey, input int nbdi,
                        input bit corrupt, input bit keep);
    logic [31:0] a, w, tb;
    logic [3:0] t;
    int n = 0;
    a = '0;
    ifc.req_mode[4*c +: 4] = mode;
    ifc.req_valid[c] = 1'b1;
    while (!ifc.req_grant[c] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      chk("grant_tmo", 0, 1);
      ifc.req_valid[c] = 1'b0;
      return;
    end
    for (int k = 0; k < nkey; k++) begin
      w = $urandom;
      a ^= w;
      ifc.ch_key[32*c +: 32] = w;
      ifc.ch_key_valid[c] = 1'b1;
      wait_rdy(c, 1'b1);
    end
    ifc.ch_key_valid[c] = 1'b0;
    for (int k = 0; k < nbdi; k++) begin
      t = (k == nbdi - 1) ? 4'hD : 4'h1;
      tb = {23'd0, k == nbdi - 1, t, 4'hF};
      w = $urandom;
      if (k == nbdi - 1 && mode == M_DEC) w = a ^ tb ^ (corrupt ? 32'hFF : 32'h0);
      a ^= w ^ tb;
      if (k == nbdi - 1) begin
        for (int j = 0; j < onum(mode); j++)
          exp_bdo.push_back(bdo_t'{c, a + 32'(j), j == onum(mode) - 1, mode});
        exp_done.push_back(done_t'{c, mode == M_DEC, mode == M_DEC && a == 32'd0});
      end
      ifc.ch_bdi[32*c +: 32] = w;
      ifc.ch_bdi_valid[4*c +: 4] = 4'hF;
      ifc.ch_bdi_type[4*c +: 4] = t;
      ifc.ch_bdi_eot[c] = k == nbdi - 1;
      ifc.ch_bdi_eoi[c] = k == nbdi - 1;
      wait_rdy(c, 1'b0);
    end
    ifc.ch_bdi_valid[4*c +: 4] = '0;
    ifc.ch_bdi_eot[c] = 1'b0;
    ifc.ch_bdi_eoi[c] = 1'b0;
    n = 0;
    while (ifc.req_grant[c] && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("release_tmo", 0, 1);
    if (!keep) ifc.req_valid[c] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.req_valid = '0; ifc.req_mode = '0; ifc.ch_key = '0; ifc.ch_key_valid = '0;
    ifc.ch_bdi = '0; ifc.ch_bdi_valid = '0; ifc.ch_bdi_type = '0; ifc.ch_bdi_eot = '0;
    ifc.ch_bdi_eoi = '0; ifc.ch_bdo_ready = '1; ifc.ch_bdo_eoo = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(ifc.busy), 0);
    chk("rst_grant", 64'(ifc.req_grant), 0);
    chk("rst_gid", 64'(ifc.grant_id), 0);
    chk("rst_mode", 64'(core_mode), 0);
    chk("rst_done", 64'(ifc.req_done | ifc.req_auth | ifc.req_auth_valid), 0);
    chk("rst_core_in", 64'({core_key_valid, core_bdi_valid, core_bdo_ready}), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      exp_gnt.push_back(gnt_t'{0, M_ENC});
      exp_gnt.push_back(gnt_t'{1, M_HASH});
      fork
        run_op(0, M_ENC, 4, 4, 1'b0, 1'b0);
        run_op(1, M_HASH, 0, 3, 1'b0, 1'b0);
      join
    end
    exp_gnt.push_back(gnt_t'{0, M_ENC});
    run_op(0, M_ENC, 4, 4, 1'b0, 1'b0);
    exp_gnt.push_back(gnt_t'{1, M_DEC});
    run_op(1, M_DEC, 4, 5, 1'b0, 1'b0);
    exp_gnt.push_back(gnt_t'{1, M_DEC});
    run_op(1, M_DEC, 4, 5, 1'b1, 1'b0);
    exp_gnt.push_back(gnt_t'{0, M_HASH});
    exp_gnt.push_back(gnt_t'{0, M_HASH});
    run_op(0, M_HASH, 0, 3, 1'b0, 1'b1);
    chk("hash_held_gap", 64'(ifc.req_valid[0]), 1);
    run_op(0, M_HASH, 0, 2, 1'b0, 1'b0);
    exp_gnt.push_back(gnt_t'{0, M_HASH});
    ifc.req_mode[3:0] = M_HASH;
    ifc.req_valid[0] = 1'b1;
    begin
      int n = 0;
      while (!ifc.req_grant[0] && n < TMO) begin
        @(negedge clk);
        n++;
      end
      chk("rst_test_grant", 64'(ifc.req_grant[0]), 1);
    end
    for (int k = 0; k < 2; k++) begin
      ifc.ch_bdi[31:0] = $urandom;
      ifc.ch_bdi_valid[3:0] = 4'hF;
      ifc.ch_bdi_type[3:0] = 4'h1;
      wait_rdy(0, 1'b0);
    end
    chk("pre_rst_busy", 64'(ifc.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(ifc.busy), 0);
    chk("midrst_grant", 64'(ifc.req_grant), 0);
    chk("midrst_gid", 64'(ifc.grant_id), 0);
    chk("midrst_done", 64'(ifc.req_done), 0);
    chk("midrst_mode", 64'(core_mode), 0);
    chk("midrst_core_in", 64'({core_bdi_valid, core_key_valid, core_bdo_ready}), 0);
    chk("midrst_bdi_rdy", 64'(ifc.ch_bdi_ready), 0);
    ifc.req_valid[0] = 1'b0;
    ifc.ch_bdi_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    exp_gnt.push_back(gnt_t'{0, M_CXOF});
    run_op(0, M_CXOF, 0, 2, 1'b0, 1'b0);
    ifc.req_mode[3:0] = 4'd0;
    ifc.req_valid[0] = 1'b1;
    exp_gnt.push_back(gnt_t'{1, M_XOF});
    run_op(1, M_XOF, 0, 2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mode0_idle", 64'(ifc.busy), 0);
    ifc.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("q_gnt_left", 64'(exp_gnt.size()), 0);
    chk("q_bdo_left", 64'(exp_bdo.size()), 0);
    chk("q_done_left", 64'(exp_done.size()), 0);
    chk("done_count", 64'(done_cnt), 11);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ascon_arbiter.md
Name: ascon_arbiter

Overview:
- Shares one ascon_core instance between NREQ independent requesters.
- Grants the core for a whole operation (AEAD enc/dec, hash, XOF, CXOF), round-robin among active requests.
- Issues the core start (mode) as a single-cycle pulse and routes all streaming handshakes to and from the granted channel.
- Detects completion and releases the core, reporting done and auth per channel.
- Sits between the system-side channel adapters and ascon_core.

Parameters:
NREQ, 2, number of requester channels (2..8)
CCW, 32, core data width (32 or 64), equal to the core's CCW
CCWD8, CCW/8, byte-valid width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; also drives ascon_core rst
req_valid  in  NREQ  per-channel operation request; held until req_done
req_mode  in  4*NREQ  per-channel mode code (M_ENC/M_DEC/M_HASH/M_XOF/M_CXOF)
req_grant  out  NREQ  one-hot, channel owns the core
req_done  out  NREQ  one-cycle completion pulse
req_auth  out  NREQ  tag-check result, valid with req_done
req_auth_valid  out  NREQ  high with req_done when a DEC completed
busy  out  1  core owned by some channel
grant_id  out  3  index of the granted channel (0 when idle)
ch_key, ch_key_valid, ch_key_ready  in/in/out  CCW*NREQ / NREQ / NREQ  per-channel key stream
ch_bdi, ch_bdi_valid, ch_bdi_type, ch_bdi_eot, ch_bdi_eoi  in  CCW*NREQ / CCWD8*NREQ / 4*NREQ / NREQ / NREQ  per-channel input stream
ch_bdi_ready  out  NREQ
ch_bdo, ch_bdo_type, ch_bdo_eot  out  CCW / 4 / 1  broadcast core output data
ch_bdo_valid  out  NREQ  per-channel output valid
ch_bdo_ready, ch_bdo_eoo  in  NREQ / NREQ
core_*  mirrored ascon_core ports  core_key, core_key_valid, core_bdi, core_bdi_valid, core_bdi_type, core_bdi_eot, core_bdi_eoi, core_mode, core_bdo_ready, core_bdo_eoo out; core_key_ready, core_bdi_ready, core_bdo, core_bdo_valid, core_bdo_type, core_bdo_eot, core_auth, core_auth_valid, core_done in

Behaviour:
- Reset: FSM=IDLE; rr pointer=0; req_grant, req_done, req_auth, req_auth_valid, busy, grant_id=0; core_mode=0. A reset mid-operation aborts the operation with no req_done; the core is reset by the same rst.
- Active request: req_valid[i] && req_mode[i]!=0. Mode 0 is ignored.
- FSM:
  - IDLE: if any active request, pick the first active index at or after the rr pointer (wrapping mod NREQ), latch it in gnt and go to START.
  - START (1 cycle): core_mode=req_mode[gnt]. This is the only cycle core_mode is nonzero. Routing is live, so the core samples key_valid and bdi_eoi. Next state: BUSY.
  - BUSY: route streams; wait for core_done==1. core_done is cleared by the core on the START edge, so the value seen in BUSY belongs to the current operation. On core_done, go to RELEASE.
  - RELEASE (1 cycle): req_done[gnt]=1; req_auth[gnt]=core_auth; req_auth_valid[gnt]=core_auth_valid. rr pointer=(gnt+1) mod NREQ. Next state: IDLE.
- Latency: request to START is 1 cycle from IDLE. RELEASE to the next START is at least 2 cycles (IDLE, START).
- req_grant[gnt] and busy are high in START, BUSY and RELEASE; grant_id=gnt. Grant does not change mid-operation regardless of other requests.
- Routing is combinational muxing, zero added latency:
  - core inputs take channel gnt's values.
  - Non-granted channels see ch_key_ready=0, ch_bdi_ready=0, ch_bdo_valid=0.
  - In IDLE, all core inputs are 0 (core_bdi_valid=0, core_key_valid=0, core_bdo_ready=0).
- ch_bdo, ch_bdo_type and ch_bdo_eot are broadcast; only ch_bdo_valid is gated per channel.
- A requester that drops req_valid before req_done is a protocol error. The grant is still held until core_done.
- grant_id width is fixed at 3; upper bits are 0 for NREQ<8.

Test Plan:
- NREQ=2, ch0 M_ENC, 16B key, 16B npub, 0 AD, 0 msg -> exactly one core_mode pulse of 4'd1; tag appears on ch_bdo_valid[0] only; req_done[0] pulses once; ch1 ready and valid stay 0.
- ch0 and ch1 both request in the same cycle, rr=0 -> ch0 served first, then ch1. After both complete, new simultaneous requests start with ch0 again (pointer wraps).
- ch1 M_DEC with correct tag -> req_auth_valid[1]=1, req_auth[1]=1; corrupt one tag byte -> req_auth[1]=0.
- ch0 holds req_valid with M_HASH through two back-to-back operations -> two START cycles, each separated by RELEASE+IDLE; core_mode never high in BUSY; two 32B digests delivered.
- rst asserted mid BUSY (during msg absorb) -> next cycle all outputs 0 and FSM IDLE, no req_done; a subsequent request completes normally.
- A request with req_mode=0 while req_valid=1 -> no grant; a concurrent ch1 M_XOF request is granted instead.
